uart_rx_data_sampler: RTL and testbench

Parametrised mid-bit oversampling and majority-vote block for the UART receive path. It takes the per-bit edge count from the RX edge/bit counter and captures NSAMP consecutive samples of the serial line, centred on the bit middle. It then emits the majority-voted bit with a one-cycle valid strobe, plus an optional noise flag. It replaces the fixed 3-sample, prescale-8 sampler and supports runtime prescale and compile-time sample count.

---
 rtl/uart_rx_data_sampler.sv | 111 +++++++++++
 tb/tb_uart_rx_data_sampler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_data_sampler.sv
// Mid-bit oversampler with majority vote for the UART receive path.
// Optional noise flag is built only when UART_RX_SAMPLER_NOISE_FLAG_EN is defined.
module uart_rx_data_sampler #(
    parameter int PRESCALE_W = 6,
    parameter int NSAMP      = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Enable,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic [PRESCALE_W-1:0] EdgeCount,
    input  logic                  SData,
    output logic                  SampledBit,
    output logic                  SampleValid,
    output logic                  NoiseErr
);

    localparam int CW = PRESCALE_W + 1;
    localparam int H  = NSAMP / 2;
    localparam logic [CW-1:0] H_W       = CW'(H);
    localparam logic [CW-1:0] MIN_PS    = CW'(NSAMP + 3);
    localparam logic [2:0]    NSAMP_CNT = 3'(NSAMP);
    localparam logic [3:0]    H_CNT     = 4'(H);

    // One extra bit of headroom so mid+h+1 never wraps at the top of the range
    logic [CW-1:0] prescale_w;
    logic [CW-1:0] edge_w;
    logic [CW-1:0] mid;
    logic [CW-1:0] win_lo;
    logic [CW-1:0] win_hi;
    logic [CW-1:0] dec_idx;
    logic          cfg_ok;
    logic          in_window;
    logic          at_decision;
    logic          decide;

    logic [NSAMP-1:0] samples;
    logic [NSAMP:0]   samples_ext;
    logic [2:0]       count;
    logic [3:0]       ones;
    logic             majority;

    function automatic logic [3:0] popcount(input logic [NSAMP-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NSAMP; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

    assign prescale_w  = {1'b0, Prescale};
    assign edge_w      = {1'b0, EdgeCount};
    assign mid         = prescale_w >> 1;
    assign win_lo      = mid - H_W;
    assign win_hi      = mid + H_W;
    assign dec_idx     = win_hi + CW'(1);
    assign cfg_ok      = (prescale_w >= MIN_PS);
    assign in_window   = cfg_ok && (edge_w >= win_lo) && (edge_w <= win_hi);
    assign at_decision = cfg_ok && (edge_w == dec_idx);
    assign decide      = Enable && at_decision && (count == NSAMP_CNT);

    assign samples_ext = {samples, SData};
    assign ones        = popcount(samples);
    assign majority    = (ones > H_CNT);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samples     <= '0;
            count       <= '0;
            SampledBit  <= 1'b0;
            SampleValid <= 1'b0;
        end else begin
            SampleValid <= 1'b0;
            if (!Enable || !cfg_ok) begin
                count <= '0;
            end else if (at_decision) begin
                // A decision needs a complete window; a partial one is simply dropped
                count <= '0;
                if (count == NSAMP_CNT) begin
                    SampledBit  <= majority;
                    SampleValid <= 1'b1;
                end
            end else if (in_window) begin
                samples <= samples_ext[NSAMP-1:0];
                if (count != NSAMP_CNT) begin
                    count <= count + 3'd1;
                end
            end
        end
    end

`ifdef UART_RX_SAMPLER_NOISE_FLAG_EN
    logic noise_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            noise_q <= 1'b0;
        end else if (decide) begin
            noise_q <= (samples != '0) && (samples != '1);
        end
    end

    assign NoiseErr = noise_q;
`else
    logic unused_decide;
    assign unused_decide = decide;
    assign NoiseErr      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_data_sampler.sv
// Scoreboard bench for uart_rx_data_sampler: NSAMP=3 and NSAMP=5 instances
// share the line stimulus and are selected by their own Enable.
module tb_uart_rx_data_sampler;

    localparam int PW = 6;

    typedef struct {
        logic b;
        logic n;
        int   c;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en3 = 1'b0;
    logic          en5 = 1'b0;
    logic [PW-1:0] prescale = 6'd8;
    logic [PW-1:0] edge_cnt = '0;
    logic          sdata = 1'b0;

    logic bit3, valid3, noise3;
    logic bit5, valid5, noise5;
    logic prev3 = 1'b0;
    logic prev5 = 1'b0;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t q3[$];
    exp_t q5[$];

    uart_rx_data_sampler #(.PRESCALE_W(PW), .NSAMP(3)) dut3 (
        .CLK(clk), .RST(rst), .Enable(en3), .Prescale(prescale), .EdgeCount(edge_cnt),
        .SData(sdata), .SampledBit(bit3), .SampleValid(valid3), .NoiseErr(noise3)
    );

    uart_rx_data_sampler #(.PRESCALE_W(PW), .NSAMP(5)) dut5 (
        .CLK(clk), .RST(rst), .Enable(en5), .Prescale(prescale), .EdgeCount(edge_cnt),
        .SData(sdata), .SampledBit(bit5), .SampleValid(valid5), .NoiseErr(noise5)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Expected {bit, noise} straight from the line pattern indexed by EdgeCount
    function automatic logic [1:0] model(input int p, input int ns, input logic [31:0] pat);
        int   h, mid, n1;
        logic b, n;
        h   = ns / 2;
        mid = p >> 1;
        n1  = 0;
        for (int i = mid - h; i <= mid + h; i++) n1 += int'(pat[i]);
        b = (n1 > h);
`ifdef UART_RX_SAMPLER_NOISE_FLAG_EN
        n = (n1 != 0) && (n1 != ns);
`else
        n = 1'b0;
`endif
        return {b, n};
    endfunction

    task automatic push_exp(input int ns, input logic [1:0] bn);
        exp_t e;
        e.b = bn[1];
        e.n = bn[0];
        e.c = cyc + 1;
        if (ns == 3) q3.push_back(e);
        else q5.push_back(e);
    endtask

    task automatic run_bit(input int p, input int ns, input int len, input logic [31:0] pat,
                           input bit push);
        int d;
        d = (p >> 1) + ns / 2 + 1;
        for (int e = 0; e < len; e++) begin
            @(negedge clk);
            edge_cnt = PW'(e);
            sdata    = pat[e];
            if (push && e == d) push_exp(ns, model(p, ns, pat));
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (valid3) begin
            checks++;
            assert (!prev3) else begin
                errors++;
                $error("FAIL valid3_consecutive: got 1 expected 0 at cycle %0d", cyc);
            end
            checks++;
            assert (q3.size() > 0) else begin
                errors++;
                $error("FAIL valid3_unexpected: got valid expected none at cycle %0d", cyc);
            end
            if (q3.size() > 0) begin
                e = q3.pop_front();
                chk("bit3", bit3, e.b);
                chk("noise3", noise3, e.n);
                checks++;
                assert (cyc == e.c) else begin
                    errors++;
                    $error("FAIL valid3_cycle: got %0d expected %0d", cyc, e.c);
                end
            end
        end
        if (valid5) begin
            checks++;
            assert (!prev5) else begin
                errors++;
                $error("FAIL valid5_consecutive: got 1 expected 0 at cycle %0d", cyc);
            end
            checks++;
            assert (q5.size() > 0) else begin
                errors++;
                $error("FAIL valid5_unexpected: got valid expected none at cycle %0d", cyc);
            end
            if (q5.size() > 0) begin
                e = q5.pop_front();
                chk("bit5", bit5, e.b);
                chk("noise5", noise5, e.n);
                checks++;
                assert (cyc == e.c) else begin
                    errors++;
                    $error("FAIL valid5_cycle: got %0d expected %0d", cyc, e.c);
                end
            end
        end
        prev3 = valid3;
        prev5 = valid5;
    end

    initial begin
        logic [1:0] last;

        repeat (3) @(negedge clk);
        chk("rst_bit3", bit3, 1'b0);
        chk("rst_valid3", valid3, 1'b0);
        chk("rst_noise3", noise3, 1'b0);
        chk("rst_bit5", bit5, 1'b0);
        chk("rst_valid5", valid5, 1'b0);
        rst = 1'b1;

        // Prescale 8, NSAMP 3: clean and noisy bits
        @(negedge clk);
        en3 = 1'b1;
        run_bit(8, 3, 8, 32'hFF, 1'b1);
        run_bit(8, 3, 8, 32'h28, 1'b1);
        run_bit(8, 3, 8, 32'h10, 1'b1);
        run_bit(8, 3, 8, 32'h00, 1'b1);

        // Enable glitch mid-window kills the bit; next full bit decides
        for (int e = 0; e < 8; e++) begin
            @(negedge clk);
            en3      = (e != 4);
            edge_cnt = PW'(e);
            sdata    = 1'b1;
        end
        run_bit(8, 3, 8, 32'hFF, 1'b1);

        // Reset mid-window with SampledBit=1
        for (int e = 0; e < 5; e++) begin
            @(negedge clk);
            edge_cnt = PW'(e);
            sdata    = 1'b1;
        end
        #1 rst = 1'b0;
        #1;
        chk("midrst_bit", bit3, 1'b0);
        chk("midrst_valid", valid3, 1'b0);
        chk("midrst_noise", noise3, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int e = 5; e < 8; e++) begin
            @(negedge clk);
            edge_cnt = PW'(e);
            sdata    = 1'b1;
        end
        run_bit(8, 3, 8, 32'hFF, 1'b1);

        // EdgeCount held at the decision index for three cycles
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            edge_cnt = (e < 6) ? PW'(e) : ((e < 9) ? 6'd6 : 6'd7);
            sdata    = (e == 3 || e == 5);
            if (e == 6) push_exp(3, model(8, 3, 32'h28));
        end
        last = model(8, 3, 32'h28);

        // Enable low: outputs hold across a would-be bit
        @(negedge clk);
        en3 = 1'b0;
        run_bit(8, 3, 8, 32'h00, 1'b0);
        chk("hold_bit", bit3, last[1]);
        chk("hold_noise", noise3, last[0]);

        // Unsupported prescales never decide
        prescale = 6'd4;
        @(negedge clk);
        en3 = 1'b1;
        for (int i = 0; i < 10; i++) run_bit(4, 3, 6, 32'h00, 1'b0);
        @(negedge clk);
        en3      = 1'b0;
        prescale = 6'd5;
        @(negedge clk);
        en3 = 1'b1;
        for (int i = 0; i < 3; i++) run_bit(5, 3, 5, 32'h00, 1'b0);
        chk("unsup_bit", bit3, last[1]);

        // NSAMP 5 at Prescale 16
        @(negedge clk);
        en3      = 1'b0;
        prescale = 6'd16;
        @(negedge clk);
        en5 = 1'b1;
        run_bit(16, 5, 16, 32'h00C0, 1'b1);
        run_bit(16, 5, 16, 32'hFFFF, 1'b1);
        run_bit(16, 5, 16, 32'h0500, 1'b1);
        @(negedge clk);
        en5 = 1'b0;
        repeat (4) @(negedge clk);

        checks++;
        assert (q3.size() == 0 && q5.size() == 0) else begin
            errors++;
            $error("FAIL missing_valid: got %0d/%0d pending expected 0/0", q3.size(), q5.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
